// File: rtl/code_check_fsm_if.sv
// code_check_fsm_if: attempt inputs and indicator outputs of the code-check stage
interface code_check_fsm_if #(
    parameter int WIDTH     = 2,
    parameter int MAX_TRIES = 3
);
    localparam int TW = $clog2(MAX_TRIES + 1);
    logic             e;
    logic             check;
    logic [WIDTH-1:0] code_ref;
    logic [WIDTH-1:0] code_in;
    logic             x;
    logic             y;
    logic             z;
    logic [1:0]       state;
    logic [TW-1:0]    tries_left;
    logic             ativacao_next;
    modport master (
        output e, check, code_ref, code_in,
        input  x, y, z, state, tries_left, ativacao_next
    );
    modport slave (
        input  e, check, code_ref, code_in,
        output x, y, z, state, tries_left, ativacao_next
    );
endinterface

// File: rtl/code_check_fsm.sv
// code_check_fsm: compares an entered code on a check strobe, counts misses, locks out after too many
module code_check_fsm #(
    parameter int WIDTH       = 2,
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 8
) (
    input logic             clk,
    input logic             rst_n,
    code_check_fsm_if.slave bus
);
    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam int CW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] GRANTED = 2'b01;
    localparam logic [1:0] DENIED  = 2'b10;
    localparam logic [1:0] LOCKED  = 2'b11;
    logic [1:0]    st, st_nx;
    logic [TW-1:0] tl, tl_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          attempt, match;
    assign attempt = bus.e && bus.check;
    assign match   = bus.code_in == bus.code_ref;
    // next state, attempt counter and lockout timer; check only matters in IDLE with e high
    always_comb begin
        st_nx  = st;
        tl_nx  = tl;
        cnt_nx = cnt;
        case (st)
            IDLE: begin
                if (attempt && match) begin
                    st_nx = GRANTED;
                    tl_nx = TW'(MAX_TRIES);
                end else if (attempt && tl > TW'(1)) begin
                    st_nx = DENIED;
                    tl_nx = tl - TW'(1);
                end else if (attempt) begin
                    st_nx  = LOCKED;
                    tl_nx  = '0;
                    cnt_nx = CW'(LOCK_CYCLES - 1);
                end
            end
            GRANTED: st_nx = bus.e ? GRANTED : IDLE;
            DENIED:  st_nx = IDLE;
            default: begin
                st_nx  = (cnt == '0) ? IDLE : LOCKED;
                tl_nx  = (cnt == '0) ? TW'(MAX_TRIES) : tl;
                cnt_nx = (cnt == '0) ? cnt : cnt - CW'(1);
            end
        endcase
    end
    // state registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st  <= IDLE;
            tl  <= TW'(MAX_TRIES);
            cnt <= '0;
        end else begin
            st  <= st_nx;
            tl  <= tl_nx;
            cnt <= cnt_nx;
        end
    end
    // Moore indicator decode from the registered state only
    always_comb begin
        bus.x             = st != IDLE;
        bus.y             = st == GRANTED;
        bus.z             = (st == IDLE) || (st == LOCKED);
        bus.ativacao_next = bus.x & bus.y & ~bus.z;
        bus.state         = st;
        bus.tries_left    = tl;
    end
endmodule

// File: tb/tb_code_check_fsm.sv
// tb_code_check_fsm: vector tables, corner sequences and randomized model check of code_check_fsm
module tb_code_check_fsm;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    code_check_fsm_if #(.WIDTH(2), .MAX_TRIES(3)) ifa ();
    code_check_fsm_if #(.WIDTH(4), .MAX_TRIES(1)) ifb ();
    code_check_fsm #(.WIDTH(2), .MAX_TRIES(3), .LOCK_CYCLES(8)) u_a (.clk(clk), .rst_n(rst_a), .bus(ifa));
    code_check_fsm #(.WIDTH(4), .MAX_TRIES(1), .LOCK_CYCLES(1)) u_b (.clk(clk), .rst_n(rst_b), .bus(ifb));

    int total = 0;
    int bad   = 0;

    typedef struct {bit e; bit chk; int cin; int st; int tries;} vec_t;
    typedef enum {M_IDLE, M_GRANT, M_DENY, M_LOCK} mode_t;
    typedef struct {mode_t mode; int tries; int lock_left;} mdl_t;

    vec_t va[27] = '{
        '{1,1,2,1,3}, '{0,0,0,0,3}, '{1,1,1,2,2}, '{1,0,1,0,2}, '{1,1,1,2,1}, '{1,0,1,0,1},
        '{1,1,1,3,0}, '{0,1,2,3,0}, '{1,1,2,3,0}, '{0,1,2,3,0}, '{1,1,2,3,0}, '{0,1,2,3,0},
        '{1,1,2,3,0}, '{0,1,2,3,0}, '{1,1,2,0,3}, '{1,1,1,2,2}, '{1,0,0,0,2}, '{1,1,1,2,1},
        '{1,0,0,0,1}, '{1,1,2,1,3}, '{0,0,0,0,3}, '{1,1,1,2,2}, '{1,1,1,0,2}, '{1,1,2,1,3},
        '{1,1,1,1,3}, '{0,1,2,0,3}, '{0,1,1,0,3}
    };
    vec_t vb[8] = '{
        '{1,1,3,3,0}, '{1,1,10,0,1}, '{0,1,3,0,1}, '{1,1,10,1,1},
        '{1,0,0,1,1}, '{0,0,0,0,1}, '{1,1,5,3,0}, '{0,0,0,0,1}
    };

    function automatic int spec_state(mode_t m);
        case (m)
            M_IDLE:  return 0;
            M_GRANT: return 1;
            M_DENY:  return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int spec_xyz(int st);
        case (st)
            0:       return 3'b001;
            1:       return 3'b110;
            2:       return 3'b100;
            default: return 3'b101;
        endcase
    endfunction

    function automatic mdl_t model_step(mdl_t m, bit e, bit c, int cin, int cref, int maxt, int lockc);
        mdl_t n = m;
        case (m.mode)
            M_IDLE: if (e && c) begin
                if (cin == cref) begin
                    n.mode = M_GRANT; n.tries = maxt;
                end else if (m.tries > 1) begin
                    n.mode = M_DENY; n.tries = m.tries - 1;
                end else begin
                    n.mode = M_LOCK; n.tries = 0; n.lock_left = lockc;
                end
            end
            M_GRANT: if (!e) n.mode = M_IDLE;
            M_DENY:  n.mode = M_IDLE;
            default: begin
                n.lock_left = m.lock_left - 1;
                if (n.lock_left == 0) begin
                    n.mode = M_IDLE; n.tries = maxt;
                end
            end
        endcase
        return n;
    endfunction

    task automatic cmp(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic obs_a(string tag, int st, int tr);
        cmp({tag, ".a.state"}, int'(ifa.state), st);
        cmp({tag, ".a.tries"}, int'(ifa.tries_left), tr);
        cmp({tag, ".a.xyz"}, int'({ifa.x, ifa.y, ifa.z}), spec_xyz(st));
        cmp({tag, ".a.act"}, int'(ifa.ativacao_next), int'(st == 1));
    endtask

    task automatic obs_b(string tag, int st, int tr);
        cmp({tag, ".b.state"}, int'(ifb.state), st);
        cmp({tag, ".b.tries"}, int'(ifb.tries_left), tr);
        cmp({tag, ".b.xyz"}, int'({ifb.x, ifb.y, ifb.z}), spec_xyz(st));
        cmp({tag, ".b.act"}, int'(ifb.ativacao_next), int'(st == 1));
    endtask

    task automatic step_a(bit e, bit c, int cin);
        ifa.e = e; ifa.check = c; ifa.code_in = 2'(cin);
        @(posedge clk); #1;
    endtask

    task automatic step_b(bit e, bit c, int cin);
        ifb.e = e; ifb.check = c; ifb.code_in = 4'(cin);
        @(posedge clk); #1;
    endtask

    initial begin
        mdl_t ma, mb;
        ifa.e = 0; ifa.check = 0; ifa.code_ref = 2'b10; ifa.code_in = '0;
        ifb.e = 0; ifb.check = 0; ifb.code_ref = 4'hA;  ifb.code_in = '0;
        rst_a = 0; rst_b = 0;
        #12;
        obs_a("reset", 0, 3);
        obs_b("reset", 0, 1);
        @(posedge clk); #1;
        rst_a = 1; rst_b = 1;

        foreach (va[i]) begin
            step_a(va[i].e, va[i].chk, va[i].cin);
            obs_a($sformatf("va%0d", i), va[i].st, va[i].tries);
        end
        foreach (vb[i]) begin
            step_b(vb[i].e, vb[i].chk, vb[i].cin);
            obs_b($sformatf("vb%0d", i), vb[i].st, vb[i].tries);
        end

        step_a(1, 1, 1); step_a(1, 0, 1);
        step_a(1, 1, 1); step_a(1, 0, 1);
        step_a(1, 1, 1);
        obs_a("lock_entry", 3, 0);
        step_a(0, 1, 2); step_a(1, 1, 2); step_a(0, 0, 2);
        obs_a("lock_mid", 3, 0);
        #2 rst_a = 0;
        #1 obs_a("async_rst", 0, 3);
        @(posedge clk); #1;
        rst_a = 1;
        step_a(1, 1, 2);
        obs_a("post_rst_match", 1, 3);
        step_a(0, 0, 0);

        rst_a = 0; rst_b = 0;
        #3 rst_a = 1; rst_b = 1;
        ma = '{M_IDLE, 3, 0};
        mb = '{M_IDLE, 1, 0};
        for (int n = 0; n < 600; n++) begin
            bit ea, ca, eb, cb;
            int cia, cib;
            ea = ($urandom % 8) != 0; ca = $urandom % 2;
            cia = ($urandom % 3 == 0) ? 2 : int'($urandom % 4);
            eb = ($urandom % 8) != 0; cb = $urandom % 2;
            cib = ($urandom % 3 == 0) ? 10 : int'($urandom % 16);
            ifa.e = ea; ifa.check = ca; ifa.code_in = 2'(cia);
            ifb.e = eb; ifb.check = cb; ifb.code_in = 4'(cib);
            ma = model_step(ma, ea, ca, cia, 2, 3, 8);
            mb = model_step(mb, eb, cb, cib, 10, 1, 1);
            @(posedge clk); #1;
            obs_a("rnd", spec_state(ma.mode), ma.tries);
            obs_b("rnd", spec_state(mb.mode), mb.tries);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
